// File: rtl/i2s_codec_emulator.sv
// i2s_codec_emulator: clock-master I2S codec stand-in. Generates BCLK/LRCK,
// serializes tx pairs onto adcdat, deserializes dacdat into rx pairs.
// Ports: clk, reset (async, active-high), enable;
//        bclk, lrck, adcdat, dacdat (serial side);
//        tx_left/tx_right/tx_valid/tx_ready (one-pair holding register);
//        rx_left/rx_right/rx_valid (received pair), underrun (frame w/o data).
module i2s_codec_emulator #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_BITS  = 32,
    parameter int BCLK_HALF  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  bclk,
    output logic                  lrck,
    output logic                  adcdat,
    input  logic                  dacdat,
    input  logic [DATA_WIDTH-1:0] tx_left,
    input  logic [DATA_WIDTH-1:0] tx_right,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_left,
    output logic [DATA_WIDTH-1:0] rx_right,
    output logic                  rx_valid,
    output logic                  underrun
);

    localparam int PW = $clog2(SLOT_BITS);
    localparam int VW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [PW-1:0] POS_LAST = PW'(SLOT_BITS - 1);
    localparam logic [PW-1:0] POS_DW   = PW'(DATA_WIDTH);
    localparam logic [VW-1:0] DIV_LAST = VW'(BCLK_HALF - 1);

    logic [VW-1:0]         div_q, div_d;
    logic                  bclk_q, bclk_d;
    logic                  lrck_q, lrck_d;
    logic [PW-1:0]         pos_q, pos_d;
    logic                  adcdat_q, adcdat_d;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_WIDTH-1:0] fr_r_q, fr_r_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0] rx_lat_q, rx_lat_d;
    logic [DATA_WIDTH-1:0] rx_left_q, rx_left_d;
    logic [DATA_WIDTH-1:0] rx_right_q, rx_right_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  underrun_q, underrun_d;
    logic                  hold_empty_q, hold_empty_d;
    logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
    logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;

    logic                  tick, fall, rise, frame_start, accept;
    logic [DATA_WIDTH-1:0] rx_next;

    // {lrck_q, pos_q} together form bit_cnt; frame start is its wrap to 0.
    assign tick        = enable && (div_q == DIV_LAST);
    assign fall        = tick && bclk_q;
    assign rise        = tick && !bclk_q;
    assign frame_start = fall && lrck_q && (pos_q == POS_LAST);
    assign accept      = tx_valid && hold_empty_q;
    assign rx_next     = (rx_sh_q << 1) | DATA_WIDTH'(dacdat);

    always_comb begin
        div_d        = div_q;
        bclk_d       = bclk_q;
        lrck_d       = lrck_q;
        pos_d        = pos_q;
        adcdat_d     = adcdat_q;
        tx_sh_d      = tx_sh_q;
        fr_r_d       = fr_r_q;
        rx_sh_d      = rx_sh_q;
        rx_lat_d     = rx_lat_q;
        rx_left_d    = rx_left_q;
        rx_right_d   = rx_right_q;
        rx_valid_d   = 1'b0;
        underrun_d   = 1'b0;
        hold_empty_d = hold_empty_q;
        hold_l_d     = hold_l_q;
        hold_r_d     = hold_r_q;

        if (!enable) begin
            div_d    = '0;
            bclk_d   = 1'b0;
            lrck_d   = 1'b1;
            pos_d    = POS_LAST;
            adcdat_d = 1'b0;
            tx_sh_d  = '0;
            fr_r_d   = '0;
            rx_sh_d  = '0;
            rx_lat_d = '0;
        end else begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                bclk_d = !bclk_q;
            end
            if (fall) begin
                if (pos_q == POS_LAST) begin
                    pos_d  = '0;
                    lrck_d = !lrck_q;
                end else begin
                    pos_d = pos_q + 1'b1;
                end
                if (pos_d == '0) begin
                    // Slot start: position 0 is the idle bit before the MSB.
                    adcdat_d = 1'b0;
                    if (lrck_d) begin
                        tx_sh_d = fr_r_q;
                    end else begin
                        tx_sh_d = hold_empty_q ? '0 : hold_l_q;
                        fr_r_d  = hold_empty_q ? '0 : hold_r_q;
                    end
                end else if (pos_d <= POS_DW) begin
                    adcdat_d = tx_sh_q[DATA_WIDTH-1];
                    tx_sh_d  = tx_sh_q << 1;
                end else begin
                    adcdat_d = 1'b0;
                end
            end
            if (rise && (pos_q != '0) && (pos_q <= POS_DW)) begin
                rx_sh_d = rx_next;
                if (pos_q == POS_DW) begin
                    if (!lrck_q) begin
                        rx_lat_d = rx_next;
                    end else begin
                        rx_left_d  = rx_lat_q;
                        rx_right_d = rx_next;
                        rx_valid_d = 1'b1;
                    end
                end
            end
        end

        // Decision uses the holding state before the edge; a pair accepted
        // on the frame-start cycle waits for the following frame.
        if (frame_start) begin
            if (hold_empty_q) begin
                underrun_d = 1'b1;
            end else begin
                hold_empty_d = 1'b1;
            end
        end
        if (accept) begin
            hold_empty_d = 1'b0;
            hold_l_d     = tx_left;
            hold_r_d     = tx_right;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q        <= '0;
            bclk_q       <= 1'b0;
            lrck_q       <= 1'b1;
            pos_q        <= POS_LAST;
            adcdat_q     <= 1'b0;
            tx_sh_q      <= '0;
            fr_r_q       <= '0;
            rx_sh_q      <= '0;
            rx_lat_q     <= '0;
            rx_left_q    <= '0;
            rx_right_q   <= '0;
            rx_valid_q   <= 1'b0;
            underrun_q   <= 1'b0;
            hold_empty_q <= 1'b1;
            hold_l_q     <= '0;
            hold_r_q     <= '0;
        end else begin
            div_q        <= div_d;
            bclk_q       <= bclk_d;
            lrck_q       <= lrck_d;
            pos_q        <= pos_d;
            adcdat_q     <= adcdat_d;
            tx_sh_q      <= tx_sh_d;
            fr_r_q       <= fr_r_d;
            rx_sh_q      <= rx_sh_d;
            rx_lat_q     <= rx_lat_d;
            rx_left_q    <= rx_left_d;
            rx_right_q   <= rx_right_d;
            rx_valid_q   <= rx_valid_d;
            underrun_q   <= underrun_d;
            hold_empty_q <= hold_empty_d;
            hold_l_q     <= hold_l_d;
            hold_r_q     <= hold_r_d;
        end
    end

    assign bclk     = bclk_q;
    assign lrck     = lrck_q;
    assign adcdat   = adcdat_q;
    assign tx_ready = hold_empty_q;
    assign rx_left  = rx_left_q;
    assign rx_right = rx_right_q;
    assign rx_valid = rx_valid_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_codec_emulator.sv
// tb_i2s_codec_emulator: scoreboard bench for the I2S codec emulator.
// Time index j counts clk edges from T0 (first frame start); sampling is 1ns after each edge.
module tb_i2s_codec_emulator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        dacdat_drv = 1'b0;
    logic        loop_en = 1'b0;
    logic        dacdat_w;
    logic [23:0] tx_left = '0;
    logic [23:0] tx_right = '0;
    logic        tx_valid = 1'b0;
    logic        bclk, lrck, adcdat, tx_ready, rx_valid, underrun;
    logic [23:0] rx_left, rx_right;

    int checks = 0;
    int errors = 0;

    logic        exp_bits[$];
    logic [47:0] exp_rx[$];
    logic [47:0] tx_pend[$];

    assign dacdat_w = loop_en ? adcdat : dacdat_drv;

    i2s_codec_emulator dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .bclk     (bclk),
        .lrck     (lrck),
        .adcdat   (adcdat),
        .dacdat   (dacdat_w),
        .tx_left  (tx_left),
        .tx_right (tx_right),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_left  (rx_left),
        .rx_right (rx_right),
        .rx_valid (rx_valid),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void push_frame_bits(logic [23:0] l, logic [23:0] r);
        for (int k = 0; k < 64; k++) begin
            int p = k % 32;
            logic [23:0] w = (k < 32) ? l : r;
            exp_bits.push_back((p >= 1 && p <= 24) ? w[24-p] : 1'b0);
        end
    endfunction

    function automatic logic ref_bit(logic [23:0] l, logic [23:0] r, int k);
        int p = k % 32;
        logic [23:0] w = (k < 32) ? l : r;
        return (p >= 1 && p <= 24) ? w[24-p] : 1'b0;
    endfunction

    // Offers queued pairs one at a time; the expected rx pair and adcdat
    // bit stream are recorded as each pair is driven.
    task automatic service();
        if (tx_valid && !tx_ready) tx_valid = 1'b0;
        if (!reset && !tx_valid && tx_ready && tx_pend.size() > 0) begin
            logic [47:0] pr = tx_pend.pop_front();
            tx_left  = pr[47:24];
            tx_right = pr[23:0];
            tx_valid = 1'b1;
            exp_rx.push_back(pr);
            push_frame_bits(pr[47:24], pr[23:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        service();
    endtask

    task automatic wait_t0();
        bit ok = 0;
        for (int i = 0; i < 64 && !ok; i++) begin
            step();
            if (lrck === 1'b0) ok = 1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL t0_wait: lrck=%b after 64 cycles, required 0", lrck);
        end
    endtask

    task automatic start_run();
        exp_rx.delete();
        exp_bits.delete();
        reset = 1'b1;
        enable = 1'b0;
        tx_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        enable = 1'b1;
        wait_t0();
    endtask

    task automatic pop_bit(int j);
        logic e;
        checks++;
        if (exp_bits.size() == 0) begin
            errors++;
            $display("FAIL adcdat_sb: queue empty at j=%0d", j);
        end else begin
            e = exp_bits.pop_front();
            if (adcdat !== e) begin
                errors++;
                $display("FAIL adcdat_bit j=%0d: got %b, required %b", j, adcdat, e);
            end
        end
    endtask

    task automatic pop_rx(int j);
        logic [47:0] e;
        checks++;
        if (exp_rx.size() == 0) begin
            errors++;
            $display("FAIL rx_sb: unexpected rx_valid at j=%0d", j);
        end else begin
            e = exp_rx.pop_front();
            if ({rx_left, rx_right} !== e) begin
                errors++;
                $display("FAIL rx_pair j=%0d: got %h/%h, required %h/%h",
                         j, rx_left, rx_right, e[47:24], e[23:0]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b1;
        step();
        step();
        checks++;
        if ({bclk, lrck, adcdat, tx_ready, rx_valid, underrun} !== 6'b010100
            || rx_left !== 24'h0 || rx_right !== 24'h0) begin
            errors++;
            $display("FAIL reset_values: got %b %h %h, required 010100 0 0",
                     {bclk, lrck, adcdat, tx_ready, rx_valid, underrun}, rx_left, rx_right);
        end
    endtask

    task automatic test_clocks();
        int nb = 0, nl = 0, nu = 0, na = 0;
        start_run();
        for (int j = 0; j < 512; j++) begin
            if (j > 0) step();
            if (bclk !== ((j % 4) >= 2)) nb++;
            if (lrck !== ((j % 256) >= 128)) nl++;
            if (underrun !== ((j % 256) == 0)) nu++;
            if (adcdat !== 1'b0) na++;
        end
        checks++;
        if (nb != 0) begin errors++; $display("FAIL bclk_wave: %0d bad cycles, required 0", nb); end
        checks++;
        if (nl != 0) begin errors++; $display("FAIL lrck_wave: %0d bad cycles, required 0", nl); end
        checks++;
        if (nu != 0) begin errors++; $display("FAIL underrun_idle: %0d bad cycles, required 0", nu); end
        checks++;
        if (na != 0) begin errors++; $display("FAIL adcdat_idle: %0d nonzero cycles, required 0", na); end
    endtask

    task automatic test_tx_pattern();
        loop_en = 1'b0;
        tx_pend.push_back({24'hABCDEF, 24'h123456});
        start_run();
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL tx_ready_after_t0: got %b, required 1", tx_ready);
        end
        for (int j = 0; j < 256; j++) begin
            if (j > 0) step();
            if (j % 4 == 2) pop_bit(j);
        end
    endtask

    task automatic test_rx_ref();
        int pulses = 0;
        logic [23:0] l = 24'h800001, r = 24'h7FFFFE;
        loop_en = 1'b0;
        dacdat_drv = 1'b0;
        start_run();
        exp_rx.push_back({l, r});
        for (int j = 0; j < 300; j++) begin
            if (j > 0) step();
            if (j % 4 == 0) dacdat_drv = ref_bit(l, r, (j / 4) % 64);
            if (rx_valid === 1'b1) begin
                pulses++;
                checks++;
                if (j != 226) begin
                    errors++;
                    $display("FAIL rx_valid_time: at j=%0d, required 226", j);
                end
                pop_rx(j);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL rx_valid_count: got %0d, required 1", pulses);
        end
        dacdat_drv = 1'b0;
    endtask

    task automatic test_loopback();
        int pulses = 0, nu = 0;
        loop_en = 1'b1;
        for (int i = 0; i < 8; i++) tx_pend.push_back({$urandom(), $urandom()} & 48'hFFFFFF_FFFFFF);
        start_run();
        for (int j = 0; j < 2048; j++) begin
            if (j > 0) step();
            if (underrun === 1'b1) nu++;
            if (rx_valid === 1'b1) begin
                pulses++;
                pop_rx(j);
            end
        end
        checks++;
        if (pulses != 8) begin errors++; $display("FAIL loop_rx_count: got %0d, required 8", pulses); end
        checks++;
        if (nu != 0) begin errors++; $display("FAIL loop_underrun: got %0d pulses, required 0", nu); end
        loop_en = 1'b0;
    endtask

    task automatic test_frame_start_accept();
        loop_en = 1'b0;
        start_run();
        for (int j = 1; j < 256; j++) step();
        tx_left  = 24'hC3A55A;
        tx_right = 24'h0F1E2D;
        tx_valid = 1'b1;
        push_frame_bits(24'h0, 24'h0);
        push_frame_bits(24'hC3A55A, 24'h0F1E2D);
        step();
        checks++;
        if ({underrun, tx_ready} !== 2'b10) begin
            errors++;
            $display("FAIL fs_accept: underrun/tx_ready got %b%b, required 10", underrun, tx_ready);
        end
        for (int j = 257; j < 768; j++) begin
            step();
            if (j % 4 == 2) pop_bit(j);
            if (j == 512) begin
                checks++;
                if ({underrun, tx_ready} !== 2'b01) begin
                    errors++;
                    $display("FAIL fs_next_load: underrun/tx_ready got %b%b, required 01",
                             underrun, tx_ready);
                end
            end
        end
    endtask

    task automatic test_reset_enable();
        int pulses = 0;
        loop_en = 1'b1;
        tx_pend.push_back({24'h111111, 24'h222222});
        tx_pend.push_back({24'h333333, 24'h444444});
        tx_pend.push_back({24'h555555, 24'h666666});
        start_run();
        for (int j = 1; j <= 456; j++) step();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bclk, lrck, adcdat, tx_ready, rx_valid, underrun} !== 6'b010100
            || rx_left !== 24'h0 || rx_right !== 24'h0) begin
            errors++;
            $display("FAIL async_reset: got %b %h %h, required 010100 0 0",
                     {bclk, lrck, adcdat, tx_ready, rx_valid, underrun}, rx_left, rx_right);
        end
        tx_valid = 1'b0;
        tx_pend.delete();
        tx_pend.push_back({24'hA5A5A5, 24'h5A5A5A});
        tx_pend.push_back({24'hFEDCBA, 24'h987654});
        start_run();
        for (int j = 1; j <= 242; j++) begin
            step();
            if (rx_valid === 1'b1) pop_rx(j);
        end
        enable = 1'b0;
        step();
        checks++;
        if ({bclk, lrck, adcdat, rx_valid, underrun} !== 5'b01000) begin
            errors++;
            $display("FAIL enable_low: got %b, required 01000",
                     {bclk, lrck, adcdat, rx_valid, underrun});
        end
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (tx_ready !== 1'b0 || {rx_left, rx_right} !== {24'hA5A5A5, 24'h5A5A5A}) begin
            errors++;
            $display("FAIL enable_retain: tx_ready %b rx %h/%h, required 0 a5a5a5/5a5a5a",
                     tx_ready, rx_left, rx_right);
        end
        enable = 1'b1;
        wait_t0();
        checks++;
        if ({tx_ready, underrun} !== 2'b10) begin
            errors++;
            $display("FAIL reenable_load: tx_ready/underrun got %b%b, required 10", tx_ready, underrun);
        end
        for (int j = 1; j < 256; j++) begin
            step();
            if (j == 127 || j == 128) begin
                checks++;
                if (lrck !== (j == 128)) begin
                    errors++;
                    $display("FAIL reenable_lrck j=%0d: got %b, required %b", j, lrck, j == 128);
                end
            end
            if (rx_valid === 1'b1) begin
                pulses++;
                checks++;
                if (j != 226) begin
                    errors++;
                    $display("FAIL reenable_rx_time: at j=%0d, required 226", j);
                end
                pop_rx(j);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL reenable_rx_count: got %0d, required 1", pulses);
        end
        loop_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clocks();
        test_tx_pattern();
        test_rx_ref();
        test_loopback();
        test_frame_start_accept();
        test_reset_enable();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
